// File: rtl/alu_arbiter.sv
// alu_arbiter: lets two valid/ready requesters share one combinational alu, one op at a time.
// Build option ALU_ARB_FIXED_PRIO_EN: requester 0 wins ties (default is round-robin).
module alu_arbiter #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,

    input  logic                  Req0Valid,
    output logic                  Req0Ready,
    input  logic [DATA_WIDTH-1:0] Req0SrcA,
    input  logic [DATA_WIDTH-1:0] Req0SrcB,
    input  logic [2:0]            Req0Ctrl,

    input  logic                  Req1Valid,
    output logic                  Req1Ready,
    input  logic [DATA_WIDTH-1:0] Req1SrcA,
    input  logic [DATA_WIDTH-1:0] Req1SrcB,
    input  logic [2:0]            Req1Ctrl,

    output logic                  Rsp0Valid,
    input  logic                  Rsp0Ready,
    output logic [DATA_WIDTH-1:0] Rsp0Result,
    output logic                  Rsp0Zero,

    output logic                  Rsp1Valid,
    input  logic                  Rsp1Ready,
    output logic [DATA_WIDTH-1:0] Rsp1Result,
    output logic                  Rsp1Zero,

    output logic [DATA_WIDTH-1:0] AluSrcA,
    output logic [DATA_WIDTH-1:0] AluSrcB,
    output logic [2:0]            AluControl,
    input  logic [DATA_WIDTH-1:0] AluResult,
    input  logic                  AluZero,

    output logic                  Busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  owner_q, owner_d;
    logic [DATA_WIDTH-1:0] srca_q, srca_d;
    logic [DATA_WIDTH-1:0] srcb_q, srcb_d;
    logic [2:0]            ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic                  last_q, last_d;
`endif

    logic any_valid;
    logic winner;
    logic grant_en;
    logic rsp_ready_own;

    // winner is only meaningful while any_valid is high
    always_comb begin
        any_valid = Req0Valid | Req1Valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
        winner = ~Req0Valid;
`else
        if (Req0Valid && Req1Valid) begin
            winner = ~last_q;
        end else begin
            winner = ~Req0Valid;
        end
`endif
        // Gating with RST keeps every output low while reset is held
        grant_en      = RST && (state_q == IDLE) && any_valid;
        rsp_ready_own = owner_q ? Rsp1Ready : Rsp0Ready;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        srca_d   = srca_q;
        srcb_d   = srcb_q;
        ctrl_d   = ctrl_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_d   = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_en) begin
                    owner_d = winner;
                    srca_d  = winner ? Req1SrcA : Req0SrcA;
                    srcb_d  = winner ? Req1SrcB : Req0SrcB;
                    ctrl_d  = winner ? Req1Ctrl : Req0Ctrl;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = AluResult;
                zero_d   = AluZero;
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready_own) begin
`ifndef ALU_ARB_FIXED_PRIO_EN
                    last_d  = owner_q;
`endif
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            srca_q   <= '0;
            srcb_q   <= '0;
            ctrl_q   <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            srca_q   <= srca_d;
            srcb_q   <= srcb_d;
            ctrl_q   <= ctrl_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q   <= last_d;
`endif
        end
    end

    assign Req0Ready  = grant_en && !winner;
    assign Req1Ready  = grant_en &&  winner;

    assign Rsp0Valid  = (state_q == RESP) && !owner_q;
    assign Rsp1Valid  = (state_q == RESP) &&  owner_q;
    assign Rsp0Result = result_q;
    assign Rsp1Result = result_q;
    assign Rsp0Zero   = zero_q;
    assign Rsp1Zero   = zero_q;

    // The op register stays put outside EXEC so the alu inputs do not toggle in IDLE
    assign AluSrcA    = srca_q;
    assign AluSrcB    = srcb_q;
    assign AluControl = ctrl_q;

    assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: transaction-level model checked every cycle plus literal expectations.
module tb_alu_arbiter;
    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         Req0Valid = 1'b0, Req1Valid = 1'b0;
    logic [W-1:0] Req0SrcA = '0, Req0SrcB = '0, Req1SrcA = '0, Req1SrcB = '0;
    logic [2:0]   Req0Ctrl = '0, Req1Ctrl = '0;
    logic         Rsp0Ready = 1'b0, Rsp1Ready = 1'b0;
    logic         Req0Ready, Req1Ready, Rsp0Valid, Rsp1Valid, Rsp0Zero, Rsp1Zero, Busy;
    logic [W-1:0] Rsp0Result, Rsp1Result, AluSrcA, AluSrcB, AluResult;
    logic [2:0]   AluControl;
    logic         AluZero;

    int checks = 0;
    int passes = 0;

    always #5 CLK = ~CLK;

    function automatic logic [W-1:0] alu_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [2:0] c);
        case (c)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b101:  return ($signed(a) < $signed(b)) ? 1 : 0;
            default: return '0;
        endcase
    endfunction

    // Attached alu
    assign AluResult = alu_res(AluSrcA, AluSrcB, AluControl);
    assign AluZero   = (AluResult == '0);

    alu_arbiter #(.DATA_WIDTH(W)) dut (
        .CLK(CLK), .RST(RST),
        .Req0Valid(Req0Valid), .Req0Ready(Req0Ready), .Req0SrcA(Req0SrcA), .Req0SrcB(Req0SrcB), .Req0Ctrl(Req0Ctrl),
        .Req1Valid(Req1Valid), .Req1Ready(Req1Ready), .Req1SrcA(Req1SrcA), .Req1SrcB(Req1SrcB), .Req1Ctrl(Req1Ctrl),
        .Rsp0Valid(Rsp0Valid), .Rsp0Ready(Rsp0Ready), .Rsp0Result(Rsp0Result), .Rsp0Zero(Rsp0Zero),
        .Rsp1Valid(Rsp1Valid), .Rsp1Ready(Rsp1Ready), .Rsp1Result(Rsp1Result), .Rsp1Zero(Rsp1Zero),
        .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .AluControl(AluControl),
        .AluResult(AluResult), .AluZero(AluZero), .Busy(Busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Transaction model: one op in flight, aged 1 while computing, 2 while offered back
    bit           m_inflight = 1'b0;
    int           m_age = 0;
    bit           m_owner = 1'b0;
    bit           m_last = 1'b1;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [2:0]   m_c = '0;
    int           grants[$];

    function automatic bit pick(input logic v0, input logic v1);
        if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            return 1'b0;
`else
            return !m_last;
`endif
        end
        return !v0;
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_inflight = 1'b0;
            m_age = 0;
            m_owner = 1'b0;
            m_last = 1'b1;
            m_a = '0;
            m_b = '0;
            m_c = '0;
        end else if (m_inflight) begin
            if (m_age == 1) m_age = 2;
            else if (m_owner ? Rsp1Ready : Rsp0Ready) begin
                m_inflight = 1'b0;
                m_last = m_owner;
            end
        end else if (Req0Valid || Req1Valid) begin
            m_owner = pick(Req0Valid, Req1Valid);
            m_a = m_owner ? Req1SrcA : Req0SrcA;
            m_b = m_owner ? Req1SrcB : Req0SrcB;
            m_c = m_owner ? Req1Ctrl : Req0Ctrl;
            grants.push_back(int'(m_owner));
            m_inflight = 1'b1;
            m_age = 1;
        end
    end

    always @(negedge CLK) begin
        logic er0, er1, ev0, ev1;
        logic [W-1:0] eres;
        er0 = 1'b0;
        er1 = 1'b0;
        if (RST && !m_inflight && (Req0Valid || Req1Valid)) begin
            if (pick(Req0Valid, Req1Valid)) er1 = 1'b1;
            else er0 = 1'b1;
        end
        ev0 = m_inflight && (m_age == 2) && !m_owner;
        ev1 = m_inflight && (m_age == 2) &&  m_owner;
        chk("cmp_req0ready", Req0Ready, er0);
        chk("cmp_req1ready", Req1Ready, er1);
        chk("cmp_rsp0valid", Rsp0Valid, ev0);
        chk("cmp_rsp1valid", Rsp1Valid, ev1);
        chk("cmp_busy", Busy, m_inflight);
        chk("cmp_alusrca", AluSrcA, m_a);
        chk("cmp_alusrcb", AluSrcB, m_b);
        chk("cmp_aluctrl", AluControl, m_c);
        eres = alu_res(m_a, m_b, m_c);
        if (ev0) begin
            chk("cmp_rsp0result", Rsp0Result, eres);
            chk("cmp_rsp0zero", Rsp0Zero, eres == '0);
        end
        if (ev1) begin
            chk("cmp_rsp1result", Rsp1Result, eres);
            chk("cmp_rsp1zero", Rsp1Zero, eres == '0);
        end
    end

    initial begin
        int busy_cnt;
        int exp_g[4];
        #2;
        chk("rst_busy", Busy, 1'b0);
        chk("rst_alusrca", AluSrcA, 32'h0);
        chk("rst_aluctrl", AluControl, 3'b000);
        chk("rst_rsp0valid", Rsp0Valid, 1'b0);
        chk("rst_rsp0result", Rsp0Result, 32'h0);
        tick();
        tick();
        RST = 1'b1;

        // Requester 0 alone: 5 + 3
        tick();
        Req0Valid = 1'b1; Req0SrcA = 5; Req0SrcB = 3; Req0Ctrl = 3'b000; Rsp0Ready = 1'b1;
        #1;
        chk("s1_req0ready", Req0Ready, 1'b1);
        chk("s1_req1ready", Req1Ready, 1'b0);
        tick();
        Req0Valid = 1'b0;
        #1;
        chk("s1_busy_exec", Busy, 1'b1);
        chk("s1_rsp0valid_exec", Rsp0Valid, 1'b0);
        tick();
        #1;
        chk("s1_rsp0valid", Rsp0Valid, 1'b1);
        chk("s1_rsp0result", Rsp0Result, 32'd8);
        chk("s1_rsp0zero", Rsp0Zero, 1'b0);
        chk("s1_rsp1valid", Rsp1Valid, 1'b0);
        tick();
        #1;
        chk("s1_busy_done", Busy, 1'b0);

        // Requester 1 alone: 7 - 7, response taken one cycle late
        Req1Valid = 1'b1; Req1SrcA = 7; Req1SrcB = 7; Req1Ctrl = 3'b001; Rsp1Ready = 1'b0;
        #1;
        chk("s2_req1ready", Req1Ready, 1'b1);
        busy_cnt = 0;
        tick();
        Req1Valid = 1'b0;
        #1;
        busy_cnt += int'(Busy);
        tick();
        #1;
        busy_cnt += int'(Busy);
        chk("s2_rsp1valid", Rsp1Valid, 1'b1);
        chk("s2_rsp1result", Rsp1Result, 32'd0);
        chk("s2_rsp1zero", Rsp1Zero, 1'b1);
        tick();
        Rsp1Ready = 1'b1;
        #1;
        busy_cnt += int'(Busy);
        tick();
        #1;
        busy_cnt += int'(Busy);
        chk("s2_busy_cycles", busy_cnt, 3);

        // Both requesters continuously valid
        grants.delete();
        Req0Valid = 1'b1; Req0SrcA = 2;     Req0SrcB = 9; Req0Ctrl = 3'b101;
        Req1Valid = 1'b1; Req1SrcA = 32'h10; Req1SrcB = 4; Req1Ctrl = 3'b001;
        #1;
        chk("s3_req0ready", Req0Ready, 1'b1);
        chk("s3_req1ready", Req1Ready, 1'b0);
        tick();
        tick();
        #1;
        chk("s3_slt_valid", Rsp0Valid, 1'b1);
        chk("s3_slt_result", Rsp0Result, 32'd1);
        repeat (8) tick();
        Req0Valid = 1'b0;
        Req1Valid = 1'b0;
        repeat (3) tick();
`ifdef ALU_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        chk("s3_grant_count", grants.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s3_grant%0d", i), (grants.size() > i) ? grants[i] : 99, exp_g[i]);
        end

        // Requester 0 stalls its response while requester 1 waits
        Rsp0Ready = 1'b0; Rsp1Ready = 1'b1;
        Req0Valid = 1'b1; Req0SrcA = 32'hF0; Req0SrcB = 32'h0F; Req0Ctrl = 3'b011;
        #1;
        chk("s4_req0ready", Req0Ready, 1'b1);
        tick();
        Req0Valid = 1'b0;
        Req1Valid = 1'b1; Req1SrcA = 32'hFFFF_FFFF; Req1SrcB = 1; Req1Ctrl = 3'b111;
        #1;
        chk("s4_req1ready_exec", Req1Ready, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("s4_hold_valid", Rsp0Valid, 1'b1);
            chk("s4_hold_result", Rsp0Result, 32'hFF);
            chk("s4_hold_req1ready", Req1Ready, 1'b0);
            tick();
        end
        Rsp0Ready = 1'b1;
        #1;
        chk("s4_still_valid", Rsp0Valid, 1'b1);
        tick();
        #1;
        chk("s4_req1_granted", Req1Ready, 1'b1);
        chk("s4_busy_idle", Busy, 1'b0);
        tick();
        Req1Valid = 1'b0;
        tick();
        #1;
        chk("s4_rsp1valid", Rsp1Valid, 1'b1);
        chk("s4_unsup_result", Rsp1Result, 32'd0);
        chk("s4_unsup_zero", Rsp1Zero, 1'b1);
        tick();

        // Op from 0 so the pointer favours 1, then reset an op from 1 during EXEC
        Req0Valid = 1'b1; Req0SrcA = 1; Req0SrcB = 1; Req0Ctrl = 3'b000;
        tick();
        Req0Valid = 1'b0;
        tick();
        tick();
        #1;
        chk("s5_busy_idle", Busy, 1'b0);
        Req1Valid = 1'b1; Req1SrcA = 3; Req1SrcB = 4; Req1Ctrl = 3'b010;
        #1;
        chk("s5_req1ready", Req1Ready, 1'b1);
        tick();
        Req1Valid = 1'b0;
        #1;
        chk("s5_busy_exec", Busy, 1'b1);
        chk("s5_alusrca_exec", AluSrcA, 32'd3);
        RST = 1'b0;
        #1;
        chk("s5_rst_busy", Busy, 1'b0);
        chk("s5_rst_alusrca", AluSrcA, 32'd0);
        chk("s5_rst_alusrcb", AluSrcB, 32'd0);
        chk("s5_rst_aluctrl", AluControl, 3'b000);
        chk("s5_rst_rsp1valid", Rsp1Valid, 1'b0);
        tick();
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("s5_no_rsp1", Rsp1Valid, 1'b0);
            chk("s5_no_rsp0", Rsp0Valid, 1'b0);
            tick();
        end
        Req0Valid = 1'b1; Req0SrcA = 32'hF; Req0SrcB = 32'hF; Req0Ctrl = 3'b001;
        Req1Valid = 1'b1; Req1SrcA = 2;     Req1SrcB = 2;     Req1Ctrl = 3'b000;
        #1;
        chk("s5_restart_req0", Req0Ready, 1'b1);
        chk("s5_restart_req1", Req1Ready, 1'b0);
        tick();
        Req0Valid = 1'b0;
        Req1Valid = 1'b0;
        tick();
        #1;
        chk("s5_rsp0valid", Rsp0Valid, 1'b1);
        chk("s5_rsp0zero", Rsp0Zero, 1'b1);
        tick();
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
